// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device-generated clocks and checks the device ACK.
//
// state    | meaning
// IDLE     | lines released, ready for a command byte
// INHIBIT  | clock held low, then start bit asserted with clock still low
// RTS      | clock released, start bit held, waiting for first device fall
// SHIFT    | presenting data, parity and stop on each device fall
// ACK      | data released, sampling device ACK on the 11th fall
// WAITIDLE | waiting for device to release both lines
// DONE     | one-cycle success pulse
// FAIL     | one-cycle failure pulse (NACK or timeout)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12500,
  parameter int START_TIMEOUT  = 1875000,
  parameter int PACKET_TIMEOUT = 250000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int maxStartPacket = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
  localparam int maxCycles      = (maxStartPacket > INHIBIT_CYCLES) ? maxStartPacket : INHIBIT_CYCLES;
  localparam int TimerW         = $clog2(maxCycles + 1);

  localparam logic [TimerW-1:0] timerMax    = '1;
  localparam logic [TimerW-1:0] inhibitLast = TimerW'(INHIBIT_CYCLES - 1);
  localparam logic [TimerW-1:0] inhibitEnd  = TimerW'(INHIBIT_CYCLES);
  localparam logic [TimerW-1:0] startLimit  = TimerW'(START_TIMEOUT - 1);
  localparam logic [TimerW-1:0] packetLimit = TimerW'(PACKET_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SHIFT, ACK, WAITIDLE, DONE, FAIL
  } stateT;

  stateT             state;
  logic [9:0]        frame;
  logic [3:0]        bitCnt;
  logic [TimerW-1:0] timer;
  logic [TimerW-1:0] timerInc;
  logic              clkOe, dataOe, txDone, txError;
  logic              clkMeta, clkSync, clkSyncD, dataMeta, dataSync;
  logic              fall;

  // Idle bus is high, so the synchronisers reset high to avoid a false fall.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      clkMeta  <= 1'b1;
      clkSync  <= 1'b1;
      clkSyncD <= 1'b1;
      dataMeta <= 1'b1;
      dataSync <= 1'b1;
    end else begin
      clkMeta  <= ps2_clk_in;
      clkSync  <= clkMeta;
      clkSyncD <= clkSync;
      dataMeta <= ps2_data_in;
      dataSync <= dataMeta;
    end
  end

  assign fall     = clkSyncD & ~clkSync;
  assign timerInc = (timer == timerMax) ? timer : timer + TimerW'(1);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= IDLE;
      frame   <= '0;
      bitCnt  <= '0;
      timer   <= '0;
      clkOe   <= 1'b0;
      dataOe  <= 1'b0;
      txDone  <= 1'b0;
      txError <= 1'b0;
    end else begin
      txDone  <= 1'b0;
      txError <= 1'b0;
      case (state)
        IDLE: begin
          clkOe  <= 1'b0;
          dataOe <= 1'b0;
          if (tx_valid) begin
            frame  <= {1'b1, ~^tx_data, tx_data};
            timer  <= '0;
            bitCnt <= '0;
            clkOe  <= 1'b1;
            state  <= INHIBIT;
          end
        end
        INHIBIT: begin
          timer <= timerInc;
          if (timer == inhibitLast) dataOe <= 1'b1;
          if (timer == inhibitEnd) begin
            clkOe <= 1'b0;
            timer <= '0;
            state <= RTS;
          end
        end
        RTS: begin
          timer <= timerInc;
          if (timer >= startLimit) begin
            state <= FAIL; clkOe <= 1'b0; dataOe <= 1'b0; txDone <= 1'b1; txError <= 1'b1;
          end else if (fall) begin
            dataOe <= ~frame[0];
            frame  <= {1'b0, frame[9:1]};
            bitCnt <= 4'd1;
            timer  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          timer <= timerInc;
          if (timer >= packetLimit) begin
            state <= FAIL; clkOe <= 1'b0; dataOe <= 1'b0; txDone <= 1'b1; txError <= 1'b1;
          end else if (fall) begin
            dataOe <= ~frame[0];
            frame  <= {1'b0, frame[9:1]};
            bitCnt <= bitCnt + 4'd1;
            if (bitCnt == 4'd9) state <= ACK;
          end
        end
        ACK: begin
          timer <= timerInc;
          if (timer >= packetLimit || (fall && dataSync)) begin
            state <= FAIL; clkOe <= 1'b0; dataOe <= 1'b0; txDone <= 1'b1; txError <= 1'b1;
          end else if (fall) begin
            state <= WAITIDLE;
          end
        end
        WAITIDLE: begin
          timer <= timerInc;
          if (timer >= packetLimit) begin
            state <= FAIL; clkOe <= 1'b0; dataOe <= 1'b0; txDone <= 1'b1; txError <= 1'b1;
          end else if (clkSync && dataSync) begin
            clkOe  <= 1'b0;
            dataOe <= 1'b0;
            txDone <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign tx_done     = txDone;
  assign tx_error    = txError;
  assign ps2_clk_oe  = clkOe;
  assign ps2_data_oe = dataOe;

endmodule
